// File: rtl/pong_ball_ctrl_if.sv
// Ball controller bus: frame timing, serve and paddle inputs
// in one direction, ball position, play state and scores in the other.
interface pong_ball_ctrl_if;
  logic       V_visible;
  logic       serve;
  logic [9:0] p1_paddle_Y;
  logic [9:0] p2_paddle_Y;
  logic [9:0] ball_X;
  logic [9:0] ball_Y;
  logic       in_play;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       paddle_hit;
  logic       point_scored;

  modport master (
    output V_visible, serve,
    output p1_paddle_Y, p2_paddle_Y,
    input  ball_X, ball_Y, in_play,
    input  score_p1, score_p2,
    input  paddle_hit, point_scored
  );

  modport slave (
    input  V_visible, serve,
    input  p1_paddle_Y, p2_paddle_Y,
    output ball_X, ball_Y, in_play,
    output score_p1, score_p2,
    output paddle_hit, point_scored
  );
endinterface

// File: rtl/pong_ball_ctrl.sv
// Per-frame pong ball motion, bounce and scoring controller.
// Optional BALL_SPEEDUP_EN: ball speeds up on each paddle hit.
module pong_ball_ctrl #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BALL_SIZE = 4,
  parameter int PADDLE_W  = 10,
  parameter int PADDLE_H  = 50,
  parameter int P1_X      = 0,
  parameter int P2_X      = 630,
  parameter int SERVE_X   = 318,
  parameter int SERVE_Y   = 238,
  parameter int SPEED     = 2
`ifdef BALL_SPEEDUP_EN
  , parameter int MAX_SPEED = 6
`endif
) (
  input logic pixel_clk,
  input logic rst,
  pong_ball_ctrl_if.slave bus
);

  localparam logic signed [11:0] L_ZERO = 12'sd0;
  localparam logic signed [11:0] L_BOT =
    12'(SCREEN_H - BALL_SIZE);
  localparam logic signed [11:0] L_BS = 12'(BALL_SIZE);
  localparam logic signed [11:0] L_PH = 12'(PADDLE_H);
  localparam logic signed [11:0] L_P1R =
    12'(P1_X + PADDLE_W);
  localparam logic signed [11:0] L_P2L = 12'(P2_X);
  localparam logic signed [11:0] L_P2HIT =
    12'(P2_X - BALL_SIZE);
  localparam logic signed [11:0] L_W = 12'(SCREEN_W);
  localparam logic [9:0] L_SX = 10'(SERVE_X);
  localparam logic [9:0] L_SY = 10'(SERVE_Y);
  localparam logic [3:0] L_SPD = 4'(SPEED);

  typedef enum logic {SERVE, PLAY} state_t;

  state_t state_q, state_d;
  logic v_r, v_prev, tick;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic dx_q, dx_d, dy_q, dy_d;
  logic [3:0] s1_q, s1_d, s2_q, s2_d;
  logic hit_q, hit_d, pt_q, pt_d;
  logic [3:0] spd;

  logic signed [11:0] cx, cy, sp, p1t, p2t;
  logic signed [11:0] nx, ny, mx, my;
  logic ndx, ndy, ov1, ov2, hit, miss1, miss2;

`ifdef BALL_SPEEDUP_EN
  localparam logic [3:0] L_MAX = 4'(MAX_SPEED);
  logic [3:0] spd_q, spd_d;
  assign spd = spd_q;
`else
  assign spd = L_SPD;
`endif

  // Start of vertical blank, seen through one register stage
  assign tick = v_prev & ~v_r;

  function automatic logic [3:0] sat_inc(
    input logic [3:0] s
  );
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  assign cx  = signed'({2'b00, x_q});
  assign cy  = signed'({2'b00, y_q});
  assign sp  = signed'({8'b0, spd});
  assign p1t = signed'({2'b00, bus.p1_paddle_Y});
  assign p2t = signed'({2'b00, bus.p2_paddle_Y});

  always_comb begin
    nx    = dx_q ? cx + sp : cx - sp;
    ny    = dy_q ? cy + sp : cy - sp;
    mx    = nx;
    my    = ny;
    ndx   = dx_q;
    ndy   = dy_q;
    hit   = 1'b0;
    miss1 = 1'b0;
    miss2 = 1'b0;
    if (ny[11]) begin
      my  = L_ZERO;
      ndy = 1'b1;
    end else if (ny > L_BOT) begin
      my  = L_BOT;
      ndy = 1'b0;
    end
    ov1 = (my + L_BS > p1t) && (my < p1t + L_PH);
    ov2 = (my + L_BS > p2t) && (my < p2t + L_PH);
    if (!dx_q) begin
      if (nx <= L_P1R) begin
        if (ov1) begin
          mx  = L_P1R;
          ndx = 1'b1;
          hit = 1'b1;
        end else if (nx <= L_ZERO) begin
          miss2 = 1'b1;
        end
      end
    end else if (nx + L_BS >= L_P2L) begin
      if (ov2) begin
        mx  = L_P2HIT;
        ndx = 1'b0;
        hit = 1'b1;
      end else if (nx + L_BS >= L_W) begin
        miss1 = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    hit_d   = 1'b0;
    pt_d    = 1'b0;
`ifdef BALL_SPEEDUP_EN
    spd_d   = spd_q;
`endif
    if (tick) begin
      unique case (state_q)
        SERVE: begin
          if (bus.serve) state_d = PLAY;
        end
        PLAY: begin
          if (miss1 | miss2) begin
            state_d = SERVE;
            x_d     = L_SX;
            y_d     = L_SY;
            dy_d    = 1'b1;
            // Re-serve heads toward the player who lost the point
            dx_d    = miss1;
            pt_d    = 1'b1;
            if (miss1) s1_d = sat_inc(s1_q);
            if (miss2) s2_d = sat_inc(s2_q);
`ifdef BALL_SPEEDUP_EN
            spd_d   = L_SPD;
`endif
          end else begin
            x_d   = mx[9:0];
            y_d   = my[9:0];
            dx_d  = ndx;
            dy_d  = ndy;
            hit_d = hit;
`ifdef BALL_SPEEDUP_EN
            if (hit)
              spd_d = (spd_q >= L_MAX) ? L_MAX
                                       : spd_q + 4'd1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      v_r     <= 1'b0;
      v_prev  <= 1'b0;
      state_q <= SERVE;
      x_q     <= L_SX;
      y_q     <= L_SY;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      s1_q    <= 4'd0;
      s2_q    <= 4'd0;
      hit_q   <= 1'b0;
      pt_q    <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      spd_q   <= L_SPD;
`endif
    end else begin
      v_r     <= bus.V_visible;
      v_prev  <= v_r;
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      hit_q   <= hit_d;
      pt_q    <= pt_d;
`ifdef BALL_SPEEDUP_EN
      spd_q   <= spd_d;
`endif
    end
  end

  assign bus.ball_X       = x_q;
  assign bus.ball_Y       = y_q;
  assign bus.in_play      = (state_q == PLAY);
  assign bus.score_p1     = s1_q;
  assign bus.score_p2     = s2_q;
  assign bus.paddle_hit   = hit_q;
  assign bus.point_scored = pt_q;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Self-checking bench for pong_ball_ctrl: vector table,
// directed corner sequences and randomized play vs a model.
module tb_pong_ball_ctrl;

  logic pixel_clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;

  pong_ball_ctrl_if bus ();

  pong_ball_ctrl dut (
    .pixel_clk(pixel_clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Reference model: position, sign of velocity, speed
  int m_x, m_y, m_sx, m_sy, m_spd;
  int m_s1, m_s2, m_hit, m_pt;
  bit m_play;
  int ticks;

  typedef struct {
    bit serve;
    int x;
    int y;
    bit play;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_x = 318; m_y = 238;
    m_sx = 1; m_sy = 1; m_spd = 2;
    m_s1 = 0; m_s2 = 0;
    m_hit = 0; m_pt = 0;
    m_play = 0;
  endtask

  task automatic m_tick(input bit srv,
                        input int p1, input int p2);
    int nx, ny, miss;
    bit ov1, ov2;
    m_hit = 0; m_pt = 0; miss = 0;
    if (!m_play) begin
      m_play = srv;
      return;
    end
    nx = m_x + m_sx * m_spd;
    ny = m_y + m_sy * m_spd;
    if (ny < 0) begin
      ny = 0; m_sy = 1;
    end else if (ny > 480 - 4) begin
      ny = 476; m_sy = -1;
    end
    ov1 = (ny + 4 > p1) && (ny < p1 + 50);
    ov2 = (ny + 4 > p2) && (ny < p2 + 50);
    if (m_sx < 0 && nx <= 10) begin
      if (ov1) begin
        nx = 10; m_sx = 1; m_hit = 1;
      end else if (nx <= 0) miss = 2;
    end else if (m_sx > 0 && nx + 4 >= 630) begin
      if (ov2) begin
        nx = 626; m_sx = -1; m_hit = 1;
      end else if (nx + 4 >= 640) miss = 1;
    end
    if (miss != 0) begin
      if (miss == 1) m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15;
      else m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15;
      m_sx = (miss == 1) ? 1 : -1;
      m_sy = 1;
      m_x = 318; m_y = 238;
      m_pt = 1; m_play = 0; m_spd = 2;
    end else begin
      m_x = nx; m_y = ny;
`ifdef BALL_SPEEDUP_EN
      if (m_hit != 0 && m_spd < 6) m_spd++;
`endif
    end
  endtask

  // One frame: 3 blank cycles then 4 visible; counts pulses
  task automatic frame(output int hits, output int pts);
    hits = 0; pts = 0;
    bus.V_visible = 1'b0;
    repeat (3) begin
      @(posedge pixel_clk); #1;
      hits += int'(bus.paddle_hit);
      pts  += int'(bus.point_scored);
    end
    bus.V_visible = 1'b1;
    repeat (4) begin
      @(posedge pixel_clk); #1;
      hits += int'(bus.paddle_hit);
      pts  += int'(bus.point_scored);
    end
  endtask

  task automatic do_tick(input bit srv, input int p1,
                         input int p2, input string nm);
    int h, p;
    bus.serve = srv;
    bus.p1_paddle_Y = 10'(p1);
    bus.p2_paddle_Y = 10'(p2);
    frame(h, p);
    m_tick(srv, p1, p2);
    if (m_play) ticks++;
    chk({nm, "_x"}, int'(bus.ball_X), m_x);
    chk({nm, "_y"}, int'(bus.ball_Y), m_y);
    chk({nm, "_play"}, int'(bus.in_play), int'(m_play));
    chk({nm, "_s1"}, int'(bus.score_p1), m_s1);
    chk({nm, "_s2"}, int'(bus.score_p2), m_s2);
    chk({nm, "_hit"}, h, m_hit);
    chk({nm, "_pt"}, p, m_pt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.V_visible = 1'b1;
    bus.serve = 1'b0;
    repeat (2) @(posedge pixel_clk);
    #1 rst = 1'b0;
    repeat (2) begin @(posedge pixel_clk); #1; end
    m_reset();
    ticks = 0;
  endtask

  // Serve then play until tick 153 with a harmless left paddle
  task automatic run_to_153();
    do_tick(1'b1, 200, 0, "pre_srv");
    ticks = 0;
    while (ticks < 153) do_tick(1'b0, 200, 0, "pre");
  endtask

  initial begin
    int h, p;
    bit got;
    tbl[0] = '{serve: 1'b0, x: 318, y: 238, play: 1'b0};
    tbl[1] = '{serve: 1'b0, x: 318, y: 238, play: 1'b0};
    tbl[2] = '{serve: 1'b1, x: 318, y: 238, play: 1'b1};
    tbl[3] = '{serve: 1'b0, x: 320, y: 240, play: 1'b1};
    tbl[4] = '{serve: 1'b1, x: 322, y: 242, play: 1'b1};
    tbl[5] = '{serve: 1'b0, x: 324, y: 244, play: 1'b1};

    bus.V_visible = 1'b1;
    bus.serve = 1'b0;
    bus.p1_paddle_Y = 10'd200;
    bus.p2_paddle_Y = 10'd0;
    do_reset();

    chk("rst_x", int'(bus.ball_X), 318);
    chk("rst_y", int'(bus.ball_Y), 238);
    chk("rst_play", int'(bus.in_play), 0);
    chk("rst_s1", int'(bus.score_p1), 0);
    chk("rst_s2", int'(bus.score_p2), 0);

    // T1: idle frames with serve low
    for (int i = 0; i < 10; i++)
      do_tick(1'b0, 200, 0, "t1");

    // T2: vector table
    for (int i = 0; i < 6; i++) begin
      bus.serve = tbl[i].serve;
      frame(h, p);
      m_tick(tbl[i].serve, 200, 0);
      chk($sformatf("tbl%0d_x", i),
          int'(bus.ball_X), tbl[i].x);
      chk($sformatf("tbl%0d_y", i),
          int'(bus.ball_Y), tbl[i].y);
      chk($sformatf("tbl%0d_play", i),
          int'(bus.in_play), int'(tbl[i].play));
      chk($sformatf("tbl%0d_pulse", i), h + p, 0);
    end
    ticks = 3;

    // T3: bottom wall bounce
    while (ticks < 121) begin
      do_tick(1'b0, 200, 0, "t3");
      if (ticks == 119)
        chk("t3_y119", int'(bus.ball_Y), 476);
      if (ticks == 120)
        chk("t3_y120", int'(bus.ball_Y), 476);
      if (ticks == 121)
        chk("t3_y121", int'(bus.ball_Y), 474);
    end

    // T4: right paddle away -> miss, p1 scores
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      do_tick(1'b0, 200, 0, "t4");
      if (bus.point_scored === 1'b0 && m_pt == 1)
        got = 1'b1;
    end
    chk("t4_point_seen", int'(got), 1);
    chk("t4_s1", int'(bus.score_p1), 1);
    chk("t4_x", int'(bus.ball_X), 318);
    chk("t4_y", int'(bus.ball_Y), 238);
    chk("t4_play", int'(bus.in_play), 0);
    do_tick(1'b1, 200, 0, "t4_srv");
    do_tick(1'b0, 200, 0, "t4_dir");

    // T6a: asynchronous reset in the middle of play
    for (int i = 0; i < 5; i++)
      do_tick(1'b0, 200, 0, "t6_pre");
    @(posedge pixel_clk); #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_x", int'(bus.ball_X), 318);
    chk("t6_rst_y", int'(bus.ball_Y), 238);
    chk("t6_rst_s1", int'(bus.score_p1), 0);
    chk("t6_rst_play", int'(bus.in_play), 0);
    @(posedge pixel_clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge pixel_clk); #1; end
    m_reset();

    // T5: paddle hit at tick 154
    run_to_153();
    do_tick(1'b0, 200, 380, "t5");
    chk("t5_x154", int'(bus.ball_X), 626);
    chk("t5_y154", int'(bus.ball_Y), 408);
    chk("t5_s1", int'(bus.score_p1), 0);
    do_tick(1'b0, 200, 380, "t5b");
`ifdef BALL_SPEEDUP_EN
    chk("t5_x155", int'(bus.ball_X), 623);
`else
    chk("t5_x155", int'(bus.ball_X), 624);
`endif

    // T6b: 16 misses on the right -> score saturates
    do_reset();
    for (int k = 0; k < 16; k++) begin
      do_tick(1'b1, 200, 1000, "sat_srv");
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
        do_tick(1'b0, 200, 1000, "sat");
        if (m_pt == 1) got = 1'b1;
      end
      chk("sat_point_seen", int'(got), 1);
    end
    chk("sat_s1", int'(bus.score_p1), 15);

    // Randomized play against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      do_tick(($urandom_range(0, 3) == 0),
              int'($urandom_range(0, 430)),
              int'($urandom_range(0, 430)), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
